// File: rtl/mmio_io_ctrl_pkg.sv
// Shared address map and register decode for the MMIO I/O controller.
package mmio_io_ctrl_pkg;

  localparam logic [31:0] MMIO_UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] MMIO_UART_RX   = 32'h8000_0004;
  localparam logic [31:0] MMIO_UART_TX   = 32'h8000_0008;
  localparam logic [31:0] MMIO_CYC_CNT   = 32'h8000_0010;
  localparam logic [31:0] MMIO_INST_CNT  = 32'h8000_0014;
  localparam logic [31:0] MMIO_CNT_RST   = 32'h8000_0018;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STATUS,
    REG_RX,
    REG_TX,
    REG_CYC,
    REG_INST,
    REG_CNT_RST
  } reg_sel_e;

  // Byte lanes are ignored: every register is a word.
  function automatic reg_sel_e decode(input logic [31:0] addr);
    logic [31:0] word;
    word = {addr[31:2], 2'b00};
    case (word)
      MMIO_UART_CTRL: return REG_STATUS;
      MMIO_UART_RX:   return REG_RX;
      MMIO_UART_TX:   return REG_TX;
      MMIO_CYC_CNT:   return REG_CYC;
      MMIO_INST_CNT:  return REG_INST;
      MMIO_CNT_RST:   return REG_CNT_RST;
      default:        return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_fifo.sv
// Byte FIFO with extra-MSB pointers; head is presented combinationally.
module io_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; empty pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO window decode, UART RX/TX buffering, cycle/instret counters, registered load data.
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DWIDTH     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              inst_retired,
  output logic [DWIDTH-1:0] rdata,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  reg_sel_e          sel;
  logic              load;
  logic              cnt_clear;
  logic [31:0]       cyc_cnt;
  logic [31:0]       inst_cnt;
  logic [DWIDTH-1:0] rdata_next;

  logic       rx_full, rx_empty, rx_pop;
  logic [7:0] rx_head;
  logic       tx_full, tx_empty, tx_push;
  logic [7:0] tx_head;

  logic unused_bits;
  assign unused_bits = ^wdata[DWIDTH-1:8];

  assign sel       = decode(addr);
  // A simultaneous store wins: the load side is suppressed entirely.
  assign load      = re && !we;
  assign cnt_clear = we && (sel == REG_CNT_RST);
  assign rx_pop    = load && (sel == REG_RX);
  assign tx_push   = we && (sel == REG_TX);

  assign rx_ready = !rst && !rx_full;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;

  io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid && rx_ready),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (wdata[7:0]),
    .pop   (tx_valid && tx_ready),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // NOTE: a default assignment first keeps this block free of inferred latches.
  always_comb begin
    rdata_next = '0;
    if (load) begin
      unique case (sel)
        REG_STATUS: rdata_next = DWIDTH'({!rx_empty, !tx_full});
        REG_RX:     rdata_next = rx_empty ? '0 : DWIDTH'(rx_head);
        REG_CYC:    rdata_next = DWIDTH'(cyc_cnt);
        REG_INST:   rdata_next = DWIDTH'(inst_cnt);
        default:    rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      rdata <= rdata_next;
      if (cnt_clear) begin
        cyc_cnt  <= '0;
        inst_cnt <= '0;
      end else begin
        cyc_cnt  <= cyc_cnt + 32'd1;
        inst_cnt <= inst_cnt + {31'd0, inst_retired};
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_mmio_io_ctrl;

  localparam int D = 8;
  localparam logic [31:0] A_STAT = 32'h8000_0000;
  localparam logic [31:0] A_RX   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_CYC  = 32'h8000_0010;
  localparam logic [31:0] A_INST = 32'h8000_0014;
  localparam logic [31:0] A_CLR  = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        re, we;
  logic [31:0] wdata;
  logic        inst_retired;
  logic [31:0] rdata;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  tx_log[$];
  logic [31:0] cyc_m, inst_m;

  always #5 clk = ~clk;

  mmio_io_ctrl #(.FIFO_DEPTH(D), .DWIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .re           (re),
    .we           (we),
    .wdata        (wdata),
    .inst_retired (inst_retired),
    .rdata        (rdata),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check pre-edge outputs, advance the model, check registered rdata.
  task automatic step();
    logic [31:0] word, exp_rd;
    int rx_n, tx_n;
    #1;
    rx_n = rx_q.size();
    tx_n = tx_q.size();
    word = {addr[31:2], 2'b00};
    check("rx_ready", {31'd0, rx_ready}, {31'd0, !rst && rx_n < D});
    check("tx_valid", {31'd0, tx_valid}, {31'd0, tx_n > 0});
    check("tx_data", {24'd0, tx_data}, (tx_n > 0) ? {24'd0, tx_q[0]} : 32'd0);

    exp_rd = 32'd0;
    if (!rst && re && !we) begin
      case (word)
        A_STAT:  exp_rd = {30'd0, rx_n > 0, tx_n < D};
        A_RX:    exp_rd = (rx_n > 0) ? {24'd0, rx_q[0]} : 32'd0;
        A_CYC:   exp_rd = cyc_m;
        A_INST:  exp_rd = inst_m;
        default: exp_rd = 32'd0;
      endcase
    end

    if (rst) begin
      rx_q.delete();
      tx_q.delete();
      cyc_m  = 32'd0;
      inst_m = 32'd0;
    end else begin
      if (re && !we && word == A_RX && rx_n > 0) void'(rx_q.pop_front());
      if (rx_valid && rx_n < D) rx_q.push_back(rx_data);
      if (tx_n > 0 && tx_ready) tx_log.push_back(tx_q.pop_front());
      if (we && word == A_TX && tx_n < D) tx_q.push_back(wdata[7:0]);
      if (we && word == A_CLR) begin
        cyc_m  = 32'd0;
        inst_m = 32'd0;
      end else begin
        cyc_m  = cyc_m + 32'd1;
        inst_m = inst_m + {31'd0, inst_retired};
      end
    end

    @(posedge clk);
    #1;
    check("rdata", rdata, exp_rd);
    @(negedge clk);
  endtask

  task automatic idle();
    re = 0; we = 0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic do_load(input logic [31:0] a);
    re = 1; we = 0; addr = a;
    step();
    idle();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    re = 0; we = 1; addr = a; wdata = d;
    step();
    idle();
  endtask

  initial begin
    rst = 1; idle(); inst_retired = 0;
    rx_data = 8'h00; rx_valid = 0; tx_ready = 0;
    cyc_m = 32'd0; inst_m = 32'd0;
    @(negedge clk);
    step();
    step();
    check("reset_rdata", rdata, 32'd0);
    rst = 0;

    // 1: counters after idle
    repeat (5) step();
    do_load(A_CYC);
    check("t1_cycles", rdata, 32'd5);
    do_load(A_INST);
    check("t1_inst", rdata, 32'd0);

    // 2: RX bytes, status, underflow
    rx_valid = 1; rx_data = 8'h41; step();
    rx_data = 8'h42; step();
    rx_valid = 0;
    do_load(A_STAT);
    check("t2_status", rdata, 32'h3);
    do_load(A_RX);
    check("t2_rx0", rdata, 32'h41);
    do_load(A_RX);
    check("t2_rx1", rdata, 32'h42);
    do_load(A_RX);
    check("t2_rx_empty", rdata, 32'h0);
    do_load(A_STAT);
    check("t2_status_empty", rdata, 32'h1);

    // 3: TX overflow then drain
    tx_ready = 0;
    for (int i = 0; i < 9; i++) begin
      do_store(A_TX, 32'hFFFF_FF00 | (32'hA0 + i));
      if (i == 7) begin
        do_load(A_STAT);
        check("t3_tx_full", rdata, 32'h0);
      end
    end
    tx_log.delete();
    tx_ready = 1;
    repeat (12) step();
    tx_ready = 0;
    check("t3_tx_count", tx_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < tx_log.size(); i++)
      check("t3_tx_byte", {24'd0, tx_log[i]}, 32'hA0 + i);

    // 4: RX backpressure
    rx_valid = 1;
    for (int i = 0; i < D + 2; i++) begin
      rx_data = 8'h10 + 8'(i);
      step();
    end
    check("t4_rx_ready_low", {31'd0, rx_ready}, 32'd0);
    rx_data = 8'h77;
    do_load(A_RX);
    check("t4_rx_head", rdata, 32'h10);
    #1;
    check("t4_rx_ready_back", {31'd0, rx_ready}, 32'd1);
    step();
    rx_valid = 0;
    for (int i = 0; i < D; i++) do_load(A_RX);
    check("t4_last_pending", rdata, 32'h77);

    // 5: clear beats increment
    inst_retired = 1;
    do_store(A_CLR, 32'h1234);
    inst_retired = 0;
    do_load(A_INST);
    check("t5_inst", rdata, 32'd0);
    do_load(A_CYC);
    check("t5_cyc", rdata, 32'd1);

    // 6: reset with 3 bytes in each FIFO
    rx_valid = 1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'hC0 + 8'(i);
      do_store(A_TX, 32'hB0 + i);
    end
    rx_valid = 0;
    inst_retired = 1; step(); inst_retired = 0;
    rst = 1; step(); rst = 0;
    #1;
    check("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
    do_load(A_STAT);
    check("t6_status", rdata, 32'h1);
    do_load(A_INST);
    check("t6_inst", rdata, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] base;
      case ($urandom_range(0, 9))
        0, 1:    base = A_STAT;
        2, 3:    base = A_RX;
        4, 5:    base = A_TX;
        6:       base = A_CYC;
        7:       base = A_INST;
        8:       base = ($urandom_range(0, 7) == 0) ? A_CLR : 32'h8000_000C;
        default: base = $urandom;
      endcase
      addr = base | 32'($urandom_range(0, 3));
      re = ($urandom_range(0, 2) != 0);
      we = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      rx_valid = $urandom_range(0, 1);
      rx_data = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      inst_retired = $urandom_range(0, 1);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0; idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
